sw_bcd_mod_counter: RTL and testbench
=====================================

# sw_bcd_mod_counter

Parametrised multi-digit BCD modulo counter for the stopwatch datapath: the next generation of the seconds/minutes digit generators. Counts up or down on a single-cycle enable strobe in the system clock domain, wraps at a configurable modulus, supports a synchronous BCD preset, and emits one-cycle carry/borrow pulses for cascading into the next stage (e.g. seconds→minutes→hours). One instance per time field; cascades chain `wrap` into the next instance's `tick`.

## Interface
- DIGITS, 2, number of BCD digits (1..4); count bus is 4*DIGITS bits, digit 0 in bits [3:0]
- MODULUS, 60, wrap modulus; legal range 2..10^DIGITS; count range 0..MODULUS-1

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; highest priority
- tick  in  1  count enable strobe; one step per cycle it is high
- up_down  in  1  direction: 1 = count up, 0 = count down; sampled only when tick=1
- load  in  1  synchronous preset request
- load_val  in  4*DIGITS  BCD preset value
- count  out  4*DIGITS  current value, BCD, registered
- wrap  out  1  one-cycle pulse: carry (up, MODULUS-1→0) or borrow (down, 0→MODULUS-1)
- at_zero  out  1  registered flag, high when count == 0
- load_err  out  1  one-cycle pulse: load rejected (illegal preset)

## Operation
- Priority per cycle: reset > load > tick > hold.
- reset=1: count←0, wrap←0, load_err←0, at_zero←1.
- load=1: load_val is legal if every nibble ≤ 9 and its decimal value < MODULUS.
  - Legal: count←load_val, load_err←0. Illegal: count unchanged, load_err←1.
  - tick in the same cycle is discarded (no step, wrap←0).
- tick=1, load=0, up_down=1:
  - count == MODULUS-1 → count←0, wrap←1.
  - else BCD increment: digit i rolls 9→0 and carries into digit i+1; all other digits hold.
- tick=1, load=0, up_down=0:
  - count == 0 → count←MODULUS-1 (BCD-encoded), wrap←1.
  - else BCD decrement: digit i rolls 0→9 and borrows from digit i+1.
- Otherwise count holds; wrap←0 and load_err←0 on every cycle not setting them.
- at_zero always reflects the registered count (updated with count).
- Modulus comparison is on the BCD-encoded value of MODULUS-1 and 0, fixed at elaboration; no binary conversion of count at runtime.
- Internal state is only the count register plus the two pulse flops; no FSM beyond this.

## Timing
- All outputs registered; no combinational input→output path.
- Latency: input sampled at edge N, result visible after edge N (one cycle).
- wrap is high for exactly the one cycle in which count shows the wrapped value (0 for up, MODULUS-1 for down). Back-to-back ticks at the wrap point give one-cycle pulses only on wrap cycles.
- Cascade: next stage's tick = this stage's wrap → the next stage steps one cycle after this stage wraps; fixed one-cycle skew per stage is accepted.
- Direction change takes effect on the first tick after it; no glitch, no extra step.
- reset asserted mid-count overrides a coincident tick/load; first step after deassertion requires a new tick.

## Test plan
- Reset: DIGITS=2, MODULUS=60, hold reset 3 cycles with tick=1 → count=0x00, at_zero=1, wrap=0, load_err=0 throughout.
- Up-count wrap: 60 consecutive ticks with up_down=1 from 0x00 → count passes 0x09→0x10, 0x59→0x00; wrap high exactly one cycle, coincident with count=0x00.
- Down-count borrow: from 0x00, one tick with up_down=0 → count=0x59, wrap=1 one cycle; next tick → 0x58, wrap=0; from 0x10 one tick → 0x09.
- Load legality: load_val=0x42 → count=0x42, load_err=0; load_val=0x60 → count unchanged, load_err=1 one cycle; load_val=0x3A → rejected, load_err=1.
- Priority: load=1 with load_val=0x15 and tick=1 same cycle → count=0x15, no step; reset=1 with load=1 → count=0x00.
- Parameter sweep: DIGITS=2, MODULUS=24 up from 0x23 → 0x00 with wrap; DIGITS=3, MODULUS=1000 from 0x999 up → 0x000 with wrap; DIGITS=1, MODULUS=10 down from 0 → 9 with wrap.

Source files
------------

// File: rtl/sw_bcd_mod_counter_if.sv
// ---------------------------------------------------------------------------
// sw_bcd_mod_counter_if
// Bundles the control and status signals of one BCD modulo counter stage.
//
// Parameters:
//   DIGITS    number of BCD digits carried on load_val/count (1..4)
//
// Signals:
//   tick      count enable strobe, one step per cycle high
//   up_down   1 = count up, 0 = count down
//   load      synchronous preset request
//   load_val  BCD preset value, digit 0 in bits [3:0]
//   count     registered BCD count
//   wrap      one-cycle carry/borrow pulse
//   at_zero   high while count is zero
//   load_err  one-cycle pulse when a preset is rejected
//
// Modports:
//   master    drives the controls and observes the status (stimulus side)
//   slave     the counter itself
// ---------------------------------------------------------------------------
interface sw_bcd_mod_counter_if #(
  parameter int DIGITS = 2
);

  logic                  tick;
  logic                  up_down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;
  logic                  at_zero;
  logic                  load_err;

  modport master (
    output tick,
    output up_down,
    output load,
    output load_val,
    input  count,
    input  wrap,
    input  at_zero,
    input  load_err
  );

  modport slave (
    input  tick,
    input  up_down,
    input  load,
    input  load_val,
    output count,
    output wrap,
    output at_zero,
    output load_err
  );

endinterface

// File: rtl/sw_bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// sw_bcd_mod_counter
// Multi-digit BCD up/down counter that wraps at MODULUS. Used as one time
// field of the stopwatch; stages cascade by feeding wrap into the next
// stage's tick.
//
// Parameters:
//   DIGITS    number of BCD digits (1..4)
//   MODULUS   wrap modulus (2..10^DIGITS); count range 0..MODULUS-1
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   reset     synchronous active-high reset, highest priority
//   bus       slave side of sw_bcd_mod_counter_if:
//               tick/up_down/load/load_val in, count/wrap/at_zero/load_err out
//
// Priority each cycle: reset > load > tick > hold. All outputs come from
// registers (at_zero is decoded straight from the count register).
// ---------------------------------------------------------------------------
module sw_bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  sw_bcd_mod_counter_if.slave  bus
);

  localparam int W = 4 * DIGITS;

  // Converts an elaboration-time integer into its BCD encoding.
  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] result;
    int           rest;
    result = '0;
    rest   = value;
    for (int i = 0; i < DIGITS; i++) begin
      result[4*i +: 4] = 4'(rest % 10);
      rest             = rest / 10;
    end
    return result;
  endfunction

  // Terminal value of the count, in BCD. Since valid BCD orders the same way
  // as the decimal value it encodes, a plain unsigned compare against this
  // constant is a decimal compare and no binary conversion is needed.
  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  logic [W-1:0] count_q;
  logic         wrap_q;
  logic         load_err_q;

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic [W-1:0] next_count;
  logic         next_wrap;
  logic         next_load_err;
  logic         load_legal;
  logic         carry;
  logic         borrow;
  logic [3:0]   nib;

  // Ripple BCD increment and decrement of the current count. Each digit
  // only changes while a carry/borrow is still propagating into it; the
  // terminal cases (MAX_BCD up, zero down) are handled by the wrap logic,
  // so these never overflow the top digit in practice.
  always_comb begin
    inc_val = count_q;
    dec_val = count_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    nib     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = count_q[4*i +: 4];
      if (carry) begin
        if (nib == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = nib + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (nib == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = nib - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // A preset is accepted only if every nibble is a decimal digit and the
  // value lies below MODULUS. The nibble check matters on its own: a value
  // like 0x0A0 compares below 0x999 but is not BCD.
  always_comb begin
    load_legal = (bus.load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        load_legal = 1'b0;
      end
    end
  end

  // Next-state selection. A load always wins over a coincident tick, and
  // the tick is dropped rather than deferred.
  always_comb begin
    next_count    = count_q;
    next_wrap     = 1'b0;
    next_load_err = 1'b0;
    if (bus.load) begin
      if (load_legal) begin
        next_count = bus.load_val;
      end else begin
        next_load_err = 1'b1;
      end
    end else if (bus.tick) begin
      if (bus.up_down) begin
        if (count_q == MAX_BCD) begin
          next_count = '0;
          next_wrap  = 1'b1;
        end else begin
          next_count = inc_val;
        end
      end else begin
        if (count_q == '0) begin
          next_count = MAX_BCD;
          next_wrap  = 1'b1;
        end else begin
          next_count = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= next_count;
      wrap_q     <= next_wrap;
      load_err_q <= next_load_err;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;
  assign bus.at_zero  = (count_q == '0);

endmodule

// File: tb/tb_sw_bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_sw_bcd_mod_counter
// Self-checking bench for sw_bcd_mod_counter. Four instances cover the
// parameter sets of interest: 2 digits mod 60, 2 digits mod 24, 3 digits
// mod 1000 and 1 digit mod 10. The mod-60 instance is driven from a table
// of directed vectors; the rest use short hand-written sequences.
// ---------------------------------------------------------------------------
module tb_sw_bcd_mod_counter;

  logic clk;
  logic rst;

  int checks;
  int failures;

  sw_bcd_mod_counter_if #(.DIGITS(2)) if60   ();
  sw_bcd_mod_counter_if #(.DIGITS(2)) if24   ();
  sw_bcd_mod_counter_if #(.DIGITS(3)) if1000 ();
  sw_bcd_mod_counter_if #(.DIGITS(1)) if10   ();

  sw_bcd_mod_counter #(.DIGITS(2), .MODULUS(60))   dut60   (.clk(clk), .reset(rst), .bus(if60));
  sw_bcd_mod_counter #(.DIGITS(2), .MODULUS(24))   dut24   (.clk(clk), .reset(rst), .bus(if24));
  sw_bcd_mod_counter #(.DIGITS(3), .MODULUS(1000)) dut1000 (.clk(clk), .reset(rst), .bus(if1000));
  sw_bcd_mod_counter #(.DIGITS(1), .MODULUS(10))   dut10   (.clk(clk), .reset(rst), .bus(if10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       tick;
    logic       up_down;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] exp_count;
    logic       exp_wrap;
    logic       exp_zero;
    logic       exp_err;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mkv(input logic r, input logic t, input logic ud,
                               input logic ld, input logic [7:0] lv,
                               input logic [7:0] ec, input logic ew,
                               input logic ez, input logic ee);
    vec_t v;
    v.rst = r; v.tick = t; v.up_down = ud; v.load = ld; v.load_val = lv;
    v.exp_count = ec; v.exp_wrap = ew; v.exp_zero = ez; v.exp_err = ee;
    return v;
  endfunction

  // Compares one observed value against its expected value.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives the mod-60 instance controls for the next clock edge.
  task automatic apply_stimulus(input vec_t v);
    rst              = v.rst;
    if60.tick        = v.tick;
    if60.up_down     = v.up_down;
    if60.load        = v.load;
    if60.load_val    = v.load_val;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    string nm;

    checks   = 0;
    failures = 0;

    rst = 1'b1;
    if60.tick = 0;   if60.up_down = 1;   if60.load = 0;   if60.load_val = '0;
    if24.tick = 0;   if24.up_down = 1;   if24.load = 0;   if24.load_val = '0;
    if1000.tick = 0; if1000.up_down = 1; if1000.load = 0; if1000.load_val = '0;
    if10.tick = 0;   if10.up_down = 1;   if10.load = 0;   if10.load_val = '0;

    //                 rst tick ud load lval   count  wrap zero err
    vecs[0]  = mkv(1, 1, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    vecs[1]  = mkv(1, 1, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    vecs[2]  = mkv(1, 1, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    vecs[3]  = mkv(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    vecs[4]  = mkv(0, 1, 0, 0, 8'h00, 8'h59, 1, 0, 0);
    vecs[5]  = mkv(0, 1, 0, 0, 8'h00, 8'h58, 0, 0, 0);
    vecs[6]  = mkv(0, 0, 0, 1, 8'h42, 8'h42, 0, 0, 0);
    vecs[7]  = mkv(0, 0, 0, 1, 8'h60, 8'h42, 0, 0, 1);
    vecs[8]  = mkv(0, 0, 0, 1, 8'h3A, 8'h42, 0, 0, 1);
    vecs[9]  = mkv(0, 0, 0, 0, 8'h00, 8'h42, 0, 0, 0);
    vecs[10] = mkv(0, 0, 0, 1, 8'h10, 8'h10, 0, 0, 0);
    vecs[11] = mkv(0, 1, 0, 0, 8'h00, 8'h09, 0, 0, 0);
    vecs[12] = mkv(0, 1, 1, 0, 8'h00, 8'h10, 0, 0, 0);
    vecs[13] = mkv(0, 1, 1, 1, 8'h15, 8'h15, 0, 0, 0);
    vecs[14] = mkv(1, 1, 1, 1, 8'h33, 8'h00, 0, 1, 0);
    vecs[15] = mkv(0, 0, 1, 1, 8'h59, 8'h59, 0, 0, 0);
    vecs[16] = mkv(0, 1, 1, 0, 8'h00, 8'h00, 1, 1, 0);
    vecs[17] = mkv(0, 1, 1, 0, 8'h00, 8'h01, 0, 0, 0);
    vecs[18] = mkv(0, 1, 0, 1, 8'h00, 8'h00, 0, 1, 0);
    vecs[19] = mkv(0, 1, 0, 0, 8'h00, 8'h59, 1, 0, 0);
    vecs[20] = mkv(0, 0, 0, 0, 8'h00, 8'h59, 0, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i]);
      step();
      check_output($sformatf("vec%0d count", i),    32'(if60.count),    32'(vecs[i].exp_count));
      check_output($sformatf("vec%0d wrap", i),     32'(if60.wrap),     32'(vecs[i].exp_wrap));
      check_output($sformatf("vec%0d at_zero", i),  32'(if60.at_zero),  32'(vecs[i].exp_zero));
      check_output($sformatf("vec%0d load_err", i), 32'(if60.load_err), 32'(vecs[i].exp_err));
    end

    // Sixty consecutive up ticks from zero: count follows a decimal model,
    // wrap only on the cycle that shows 0x00.
    rst = 1'b1; if60.tick = 0; if60.load = 0; if60.up_down = 1;
    step();
    rst = 1'b0;
    if60.tick = 1'b1;
    e = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      e = k % 60;
      nm = $sformatf("up60 tick%0d", k);
      check_output({nm, " count"}, 32'(if60.count), 32'(((e / 10) << 4) | (e % 10)));
      check_output({nm, " wrap"},  32'(if60.wrap),  32'(e == 0));
    end
    if60.tick = 1'b0;
    step();
    check_output("up60 idle wrap", 32'(if60.wrap), 32'h0);

    // Mod-24: 23 up wraps to 00, 00 down wraps to 23.
    if24.load = 1; if24.load_val = 8'h23;
    step();
    if24.load = 0; if24.tick = 1; if24.up_down = 1;
    step();
    check_output("mod24 up count", 32'(if24.count), 32'h00);
    check_output("mod24 up wrap",  32'(if24.wrap),  32'h1);
    if24.up_down = 0;
    step();
    check_output("mod24 down count", 32'(if24.count), 32'h23);
    check_output("mod24 down wrap",  32'(if24.wrap),  32'h1);
    if24.load = 1; if24.load_val = 8'h24; if24.tick = 0;
    step();
    check_output("mod24 load24 count", 32'(if24.count),    32'h23);
    check_output("mod24 load24 err",   32'(if24.load_err), 32'h1);
    if24.load = 0;

    // Mod-1000: full-width carry/borrow and the non-BCD preset check.
    if1000.load = 1; if1000.load_val = 12'h999;
    step();
    check_output("mod1000 load999", 32'(if1000.count), 32'h999);
    if1000.load = 0; if1000.tick = 1; if1000.up_down = 1;
    step();
    check_output("mod1000 up count", 32'(if1000.count), 32'h000);
    check_output("mod1000 up wrap",  32'(if1000.wrap),  32'h1);
    check_output("mod1000 at_zero",  32'(if1000.at_zero), 32'h1);
    if1000.tick = 0; if1000.load = 1; if1000.load_val = 12'h0A0;
    step();
    check_output("mod1000 load0A0 count", 32'(if1000.count),    32'h000);
    check_output("mod1000 load0A0 err",   32'(if1000.load_err), 32'h1);
    if1000.load_val = 12'h199;
    step();
    if1000.load = 0; if1000.tick = 1; if1000.up_down = 1;
    step();
    check_output("mod1000 199 up", 32'(if1000.count), 32'h200);
    check_output("mod1000 199 wrap", 32'(if1000.wrap), 32'h0);
    if1000.up_down = 0;
    step();
    check_output("mod1000 200 down", 32'(if1000.count), 32'h199);
    if1000.tick = 0;

    // Mod-10 single digit: 0 down wraps to 9, then plain decrement.
    rst = 1'b1;
    step();
    rst = 1'b0; if10.tick = 1; if10.up_down = 0;
    step();
    check_output("mod10 down count", 32'(if10.count), 32'h9);
    check_output("mod10 down wrap",  32'(if10.wrap),  32'h1);
    step();
    check_output("mod10 down2 count", 32'(if10.count), 32'h8);
    check_output("mod10 down2 wrap",  32'(if10.wrap),  32'h0);
    if10.tick = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
